// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types for the fetch queue: machine word, ring entry and default depth.
package instruction_fetch_queue_pkg;

  typedef logic [31:0] word;

  typedef struct packed {
    word addr;
    word instr;
  } fetch_entry;

  localparam int FETCH_DEPTH = 4;

  // Ring pointers carry one extra wrap bit above the index bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-stage bus: PC hand-off, instruction-memory request/response and decode hand-off.
// master = the fetch queue, slave = its surroundings (program_counter, memory, decode).
interface instruction_fetch_queue_if;
  import instruction_fetch_queue_pkg::*;

  word  instruction_addr;
  logic pc_advance;
  logic flush;
  logic imem_req_valid;
  word  imem_req_addr;
  logic imem_req_ready;
  logic imem_resp_valid;
  word  imem_resp_data;
  logic out_valid;
  word  out_instr;
  word  out_addr;
  logic out_ready;

  modport master (
    input  instruction_addr, flush, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    output pc_advance, imem_req_valid, imem_req_addr, out_valid, out_instr, out_addr
  );

  modport slave (
    output instruction_addr, flush, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
    input  pc_advance, imem_req_valid, imem_req_addr, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instruction_fetch_queue_ring_buffer.sv
// DEPTH-entry storage for fetched instructions. The address half is written at issue
// time (tail), the instruction half when its response returns (fill); head is read async.
module fetch_ring_buffer
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           addr_we,
  input  logic [IW-1:0]  addr_idx,
  input  word            addr_wdata,
  input  logic           instr_we,
  input  logic [IW-1:0]  instr_idx,
  input  word            instr_wdata,
  input  logic [IW-1:0]  rd_idx,
  output fetch_entry     rd_entry
);
  fetch_entry mem [DEPTH];

  // Entries are cleared on reset so the head read shows zeros while the queue is idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (addr_we)  mem[addr_idx].addr   <= addr_wdata;
      if (instr_we) mem[instr_idx].instr <= instr_wdata;
    end
  end

  assign rd_entry = mem[rd_idx];
endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch queue between program_counter and decode. Three wrap-bit pointers track the ring:
// tail = next issue slot, fill = next response slot, head = next dequeue slot.
// A flush clears the ring and converts every unanswered request into a pending drop.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH  // power of 2, >= 2
) (
  input logic                        clock,
  input logic                        reset,
  instruction_fetch_queue_if.master  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam int DW = IW + 2;

  logic [PW-1:0] head, fill, tail;
  logic [PW-1:0] live, filled, inflight;
  logic [DW-1:0] drop_count;
  logic          issue, resp_drop, resp_fill, deq;
  fetch_entry    head_entry;

  assign live     = tail - head;
  assign filled   = fill - head;
  assign inflight = tail - fill;

  // Issue looks only at registered occupancy: a slot freed by this cycle's dequeue is
  // not reusable until next cycle, which keeps the ready path short.
  assign bus.imem_req_valid = !reset && !bus.flush && (live < PW'(DEPTH));
  assign bus.imem_req_addr  = bus.instruction_addr;
  assign issue              = bus.imem_req_valid && bus.imem_req_ready;
  assign bus.pc_advance     = issue;

  // Responses owed to pre-flush requests are swallowed first; memory answers in order.
  assign resp_drop = bus.imem_resp_valid && (drop_count != '0);
  assign resp_fill = bus.imem_resp_valid && (drop_count == '0) && !bus.flush;

  assign bus.out_valid = (filled != '0);
  assign deq           = bus.out_valid && bus.out_ready && !bus.flush;
  assign bus.out_instr = head_entry.instr;
  assign bus.out_addr  = head_entry.addr;

  fetch_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clock       (clock),
    .reset       (reset),
    .addr_we     (issue),
    .addr_idx    (tail[IW-1:0]),
    .addr_wdata  (bus.instruction_addr),
    .instr_we    (resp_fill),
    .instr_idx   (fill[IW-1:0]),
    .instr_wdata (bus.imem_resp_data),
    .rd_idx      (head[IW-1:0]),
    .rd_entry    (head_entry)
  );

  // Pointer and drop bookkeeping; flush overrides issue, fill and dequeue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      fill       <= '0;
      tail       <= '0;
      drop_count <= '0;
    end else if (bus.flush) begin
      head <= '0;
      fill <= '0;
      tail <= '0;
      // Everything still unanswered after this cycle is owed a drop; a response
      // landing in the flush cycle itself answers one of them and is discarded.
      drop_count <= drop_count + DW'(inflight) - DW'(bus.imem_resp_valid);
    end else begin
      if (issue)     tail       <= tail + PW'(1);
      if (resp_fill) fill       <= fill + PW'(1);
      if (resp_drop) drop_count <= drop_count - DW'(1);
      if (deq)       head       <= head + PW'(1);
    end
  end

  // A response with nothing outstanding and nothing to drop means memory misbehaved.
  a_resp_orphan: assert property (@(posedge clock) disable iff (reset)
    (bus.imem_resp_valid && drop_count == '0) |-> (fill != tail));

  // Drop count must never wrap when a flush adds the unanswered requests to it.
  a_drop_sat: assert property (@(posedge clock) disable iff (reset)
    bus.flush |-> (({1'b0, drop_count} + (DW+1)'(inflight)) < (DW+1)'(1 << DW)));
endmodule
